// File: rtl/tensor_operand_loader.sv
// Fetches a 4x4 int8 operand pair (A row-major into rs, B transposed into rt)
// from word memory, optionally converting fp8 E4M3 elements to saturated int8.
module tensor_operand_loader (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   base_a,
  input  logic [7:0]   base_b,
  input  logic         fmt,
  output logic         mem_read_valid,
  output logic [7:0]   mem_read_address,
  input  logic         mem_read_ready,
  input  logic [31:0]  mem_read_data,
  output logic [127:0] rs,
  output logic [127:0] rt,
  output logic         done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [7:0]     r_base_a;
  logic [7:0]     r_base_b;
  logic           r_fmt;
  logic [3:0]     r_cnt;
  logic [127:0]   r_rs;
  logic [127:0]   r_rt;
  logic [127:0]   w_rs_next;
  logic [127:0]   w_rt_next;
  logic [31:0]    w_conv;
  logic [7:0]     w_word_addr;
  logic           w_accept;
  logic           w_start_accept;

  assign w_accept       = (r_state == ST_REQ) && mem_read_ready;
  assign w_start_accept = (r_state == ST_IDLE) && start;

  // Words 0..3 come from A, 4..7 from B; the 8-bit add wraps naturally.
  assign w_word_addr = ((r_cnt[3:2] == 2'd0) ? r_base_a : r_base_b) + {6'd0, r_cnt[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_REQ;
      ST_REQ:  if (mem_read_ready) w_state_next = ST_ACK;
      ST_ACK:  w_state_next = (r_cnt == 4'd8) ? ST_DONE : ST_REQ;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_read_valid = 1'b0;
    done           = 1'b0;
    case (r_state)
      ST_REQ:  mem_read_valid = 1'b1;
      ST_DONE: done           = 1'b1;
      default: ;
    endcase
  end

  assign mem_read_address = w_word_addr;
  assign rs               = r_rs;
  assign rt               = r_rt;

  // One fp8 -> int8 converter per byte lane of the incoming word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_conv
    logic [7:0]  w_byte;
    logic [3:0]  w_exp;
    logic [11:0] w_mant;
    logic [11:0] w_mag;
    logic [6:0]  w_sat;
    logic [7:0]  w_fp;

    assign w_byte = mem_read_data[8*gi +: 8];
    assign w_exp  = w_byte[6:3];
    assign w_mant = {8'd0, 1'b1, w_byte[2:0]};
    assign w_mag  = (w_exp == 4'd0)  ? 12'd0 :
                    (w_exp <= 4'd10) ? (w_mant >> (4'd10 - w_exp)) :
                                       (w_mant << (w_exp - 4'd10));
    assign w_sat  = (w_mag > 12'd127) ? 7'd127 : w_mag[6:0];
    assign w_fp   = w_byte[7] ? (8'd0 - {1'b0, w_sat}) : {1'b0, w_sat};
    assign w_conv[8*gi +: 8] = r_fmt ? w_fp : w_byte;
  end

  // rs byte i*4+j takes lane j of word i; rt byte j*4+k takes lane j of word 4+k.
  for (genvar gi = 0; gi < 16; gi++) begin : g_store
    localparam logic [3:0] LP_RS_WORD = 4'(gi / 4);
    localparam int         LP_RS_LANE = gi % 4;
    localparam logic [3:0] LP_RT_WORD = 4'(4 + (gi % 4));
    localparam int         LP_RT_LANE = gi / 4;

    assign w_rs_next[8*gi +: 8] = (w_accept && (r_cnt == LP_RS_WORD)) ?
                                  w_conv[8*LP_RS_LANE +: 8] : r_rs[8*gi +: 8];
    assign w_rt_next[8*gi +: 8] = (w_accept && (r_cnt == LP_RT_WORD)) ?
                                  w_conv[8*LP_RT_LANE +: 8] : r_rt[8*gi +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_base_a <= 8'd0;
      r_base_b <= 8'd0;
      r_fmt    <= 1'b0;
      r_cnt    <= 4'd0;
      r_rs     <= 128'd0;
      r_rt     <= 128'd0;
    end else begin
      if (w_start_accept) begin
        r_base_a <= base_a;
        r_base_b <= base_b;
        r_fmt    <= fmt;
        r_cnt    <= 4'd0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + 4'd1;
      end
      r_rs <= w_rs_next;
      r_rt <= w_rt_next;
    end
  end

endmodule

// File: tb/tb_tensor_operand_loader.sv
// Directed bench for tensor_operand_loader: word memory model, per-scenario
// tasks with inline checks against hand-computed operands and timings.
module tb_tensor_operand_loader;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [7:0]   base_a;
  logic [7:0]   base_b;
  logic         fmt;
  logic         mem_read_valid;
  logic [7:0]   mem_read_address;
  logic         mem_read_ready;
  logic [31:0]  mem_read_data;
  logic [127:0] rs;
  logic [127:0] rt;
  logic         done;

  logic [31:0] mem [0:255];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_read_address];

  tensor_operand_loader dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .base_a           (base_a),
    .base_b           (base_b),
    .fmt              (fmt),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .rs               (rs),
    .rt               (rt),
    .done             (done)
  );

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
  endtask

  // Runs one load; the cycle holding start is cycle 1. Returns the cycle in
  // which done was seen (-1 on timeout) and the accepted address sequence.
  task automatic do_load(input logic [7:0] ba, input logic [7:0] bb, input logic f,
                         input int stall_word, input int stall_n, input int glitch_cyc,
                         output int done_cyc, output logic [63:0] addr_seq,
                         output int stall_bad, output logic pulse_bad);
    int cyc;
    int accepted;
    int stalls;
    logic [7:0] stall_addr;
    done_cyc = -1;
    addr_seq = 64'd0;
    stall_bad = 0;
    pulse_bad = 1'b0;
    accepted = 0;
    stalls = 0;
    stall_addr = ba + 8'(stall_word);
    @(negedge clk);
    base_a = ba;
    base_b = bb;
    fmt = f;
    start = 1'b1;
    mem_read_ready = 1'b1;
    cyc = 1;
    while (cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      if (cyc == glitch_cyc) begin
        start = 1'b1;
        base_a = 8'hAA;
        base_b = 8'hBB;
        fmt = ~f;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (mem_read_valid) begin
        if (accepted == stall_word && stalls < stall_n) begin
          if (mem_read_address !== stall_addr) stall_bad++;
          mem_read_ready = 1'b0;
          stalls++;
        end else begin
          mem_read_ready = 1'b1;
          if (accepted < 8) addr_seq[8*accepted +: 8] = mem_read_address;
          accepted++;
        end
      end else begin
        mem_read_ready = 1'b1;
      end
    end
    start = 1'b0;
    if (done_cyc > 0) begin
      @(posedge clk);
      #1;
      if (done) pulse_bad = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    base_a = 8'h00;
    base_b = 8'h00;
    fmt = 1'b0;
    mem_read_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (mem_read_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", mem_read_valid); end
    vectors++;
    if (mem_read_address !== 8'h00) begin miscompares++; $display("FAIL reset_addr got=%h exp=00", mem_read_address); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
    vectors++;
    if (rs !== 128'd0) begin miscompares++; $display("FAIL reset_rs got=%h exp=0", rs); end
    vectors++;
    if (rt !== 128'd0) begin miscompares++; $display("FAIL reset_rt got=%h exp=0", rt); end
    $display("reset: outputs sampled after reset release");
  endtask

  task automatic load_int8_mem();
    mem[8'h10] = 32'h03020100; mem[8'h11] = 32'h07060504;
    mem[8'h12] = 32'h0B0A0908; mem[8'h13] = 32'h0F0E0D0C;
    mem[8'h20] = 32'h03020100; mem[8'h21] = 32'h07060504;
    mem[8'h22] = 32'h0B0A0908; mem[8'h23] = 32'h0F0E0D0C;
  endtask

  task automatic test_int8_transpose();
    int dc, sb;
    logic [63:0] seq;
    logic pb;
    clear_mem();
    load_int8_mem();
    do_load(8'h10, 8'h20, 1'b0, -1, 0, -1, dc, seq, sb, pb);
    $display("int8 load: done at cycle %0d rs=%h rt=%h", dc, rs, rt);
    vectors++;
    if (dc != 18) begin miscompares++; $display("FAIL int8_latency got=%0d exp=18", dc); end
    vectors++;
    if (seq !== 64'h2322212013121110) begin miscompares++; $display("FAIL int8_addr_seq got=%h exp=2322212013121110", seq); end
    vectors++;
    if (rs !== 128'h0F0E0D0C0B0A09080706050403020100) begin miscompares++; $display("FAIL int8_rs got=%h exp=0f0e0d0c0b0a09080706050403020100", rs); end
    vectors++;
    if (rt !== 128'h0F0B07030E0A06020D0905010C080400) begin miscompares++; $display("FAIL transpose_rt got=%h exp=0f0b07030e0a06020d0905010c080400", rt); end
    vectors++;
    if (pb !== 1'b0) begin miscompares++; $display("FAIL int8_done_width got=%b exp=0", pb); end
  endtask

  task automatic test_fp8_convert();
    int dc, sb;
    logic [63:0] seq;
    logic pb;
    clear_mem();
    mem[8'h40] = 32'h3848C84C;
    mem[8'h41] = 32'h30FF7F80;
    mem[8'h42] = 32'hD7510958;
    mem[8'h50] = 32'h3848C84C;
    do_load(8'h40, 8'h50, 1'b1, -1, 0, -1, dc, seq, sb, pb);
    $display("fp8 load: done at cycle %0d rs=%h rt=%h", dc, rs, rt);
    vectors++;
    if (dc != 18) begin miscompares++; $display("FAIL fp8_latency got=%0d exp=18", dc); end
    vectors++;
    if (rs !== 128'h00000000F109001000817F000104FC06) begin miscompares++; $display("FAIL fp8_rs got=%h exp=00000000f109001000817f000104fc06", rs); end
    vectors++;
    if (rt !== 128'h00000001000000040000_00FC00000006) begin miscompares++; $display("FAIL fp8_rt got=%h exp=0000000100000004000000fc00000006", rt); end
  endtask

  task automatic test_stall();
    int dc, sb;
    logic [63:0] seq;
    logic pb;
    clear_mem();
    load_int8_mem();
    do_load(8'h10, 8'h20, 1'b0, 2, 5, -1, dc, seq, sb, pb);
    $display("stall load: done at cycle %0d stall address errors %0d", dc, sb);
    vectors++;
    if (dc != 23) begin miscompares++; $display("FAIL stall_latency got=%0d exp=23", dc); end
    vectors++;
    if (sb != 0) begin miscompares++; $display("FAIL stall_addr_stable got=%0d exp=0", sb); end
    vectors++;
    if (seq !== 64'h2322212013121110) begin miscompares++; $display("FAIL stall_addr_seq got=%h exp=2322212013121110", seq); end
    vectors++;
    if (rs !== 128'h0F0E0D0C0B0A09080706050403020100) begin miscompares++; $display("FAIL stall_rs got=%h exp=0f0e0d0c0b0a09080706050403020100", rs); end
  endtask

  task automatic test_wrap_and_start_ignore();
    int dc, sb;
    logic [63:0] seq;
    logic pb;
    clear_mem();
    mem[8'hFE] = 32'h33221100;
    mem[8'hFF] = 32'h77665544;
    mem[8'h00] = 32'hBBAA9988;
    mem[8'h01] = 32'hFFEEDDCC;
    do_load(8'h60, 8'hFE, 1'b0, -1, 0, 4, dc, seq, sb, pb);
    $display("wrap load: done at cycle %0d addr_seq=%h rt=%h", dc, seq, rt);
    vectors++;
    if (dc != 18) begin miscompares++; $display("FAIL wrap_latency got=%0d exp=18", dc); end
    vectors++;
    if (seq !== 64'h0100FFFE63626160) begin miscompares++; $display("FAIL wrap_addr_seq got=%h exp=0100fffe63626160", seq); end
    vectors++;
    if (rt !== 128'hFFBB7733EEAA6622DD995511CC884400) begin miscompares++; $display("FAIL wrap_rt got=%h exp=ffbb7733eeaa6622dd995511cc884400", rt); end
    vectors++;
    if (rs !== 128'd0) begin miscompares++; $display("FAIL wrap_rs got=%h exp=0", rs); end
  endtask

  task automatic test_reset_midload();
    int cyc;
    int pulses;
    int valids;
    clear_mem();
    load_int8_mem();
    @(negedge clk);
    base_a = 8'h10;
    base_b = 8'h20;
    fmt = 1'b0;
    mem_read_ready = 1'b1;
    start = 1'b1;
    cyc = 1;
    while (cyc < 7) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    $display("abort: reset applied in cycle 7 of a load");
    vectors++;
    if (mem_read_valid !== 1'b0) begin miscompares++; $display("FAIL abort_valid got=%b exp=0", mem_read_valid); end
    vectors++;
    if (mem_read_address !== 8'h00) begin miscompares++; $display("FAIL abort_addr got=%h exp=00", mem_read_address); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL abort_done got=%b exp=0", done); end
    vectors++;
    if (rs !== 128'd0) begin miscompares++; $display("FAIL abort_rs got=%h exp=0", rs); end
    vectors++;
    if (rt !== 128'd0) begin miscompares++; $display("FAIL abort_rt got=%h exp=0", rt); end
    pulses = 0;
    valids = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
      if (mem_read_valid) valids++;
    end
    vectors++;
    if (pulses != 0) begin miscompares++; $display("FAIL abort_no_done got=%0d exp=0", pulses); end
    vectors++;
    if (valids != 0) begin miscompares++; $display("FAIL abort_stays_idle got=%0d exp=0", valids); end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    base_a = 8'h10;
    base_b = 8'h20;
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    $display("priority: reset and start applied together");
    vectors++;
    if (mem_read_valid !== 1'b0) begin miscompares++; $display("FAIL priority_valid got=%b exp=0", mem_read_valid); end
    vectors++;
    if (mem_read_address !== 8'h00) begin miscompares++; $display("FAIL priority_addr got=%h exp=00", mem_read_address); end
  endtask

  task automatic test_back_to_back();
    int dc, sb;
    logic [63:0] seq;
    logic pb;
    clear_mem();
    load_int8_mem();
    do_load(8'h10, 8'h20, 1'b0, -1, 0, -1, dc, seq, sb, pb);
    $display("reload 1: done at cycle %0d", dc);
    vectors++;
    if (dc != 18) begin miscompares++; $display("FAIL reload1_latency got=%0d exp=18", dc); end
    mem[8'h30] = 32'h3848C84C;
    do_load(8'h30, 8'h34, 1'b1, -1, 0, -1, dc, seq, sb, pb);
    $display("reload 2: done at cycle %0d rs=%h", dc, rs);
    vectors++;
    if (dc != 18) begin miscompares++; $display("FAIL reload2_latency got=%0d exp=18", dc); end
    vectors++;
    if (rs !== 128'h000000000000000000000000_0104FC06) begin miscompares++; $display("FAIL reload2_rs got=%h exp=0104fc06 in low word", rs); end
    vectors++;
    if (rt !== 128'd0) begin miscompares++; $display("FAIL reload2_rt got=%h exp=0", rt); end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_int8_transpose();
    test_fp8_convert();
    test_stall();
    test_wrap_and_start_ignore();
    test_reset_midload();
    test_reset_priority();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
